fixed_add_sub: RTL and testbench

FIXED_ADD_SUB -- requirements
Module: fixed_add_sub

---
 rtl/fixed_pkg.sv | 15 +
 rtl/fixed_sat.sv | 26 ++
 rtl/fixed_add_sub.sv | 81 ++++++++
 tb/tb_fixed_add_sub.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fixed_pkg.sv
// Shared fixed-point format constants for the add/sub and cordic-stage blocks.
// Latency: none (constants only).
// Backpressure: not applicable.
package fixed_pkg;

    // Total signed word width including the sign bit.
    localparam int WORD_LENGTH = 21;
    // Binary point position. Informational only: the arithmetic never looks at it.
    localparam int FRAC_BITS   = 16;

    // Extremes of the signed word, used as clamp targets on overflow.
    localparam logic signed [WORD_LENGTH-1:0] MAX = {1'b0, {(WORD_LENGTH-1){1'b1}}};
    localparam logic signed [WORD_LENGTH-1:0] MIN = {1'b1, {(WORD_LENGTH-1){1'b0}}};

endpackage

// File: rtl/fixed_sat.sv
// Narrows a one-bit-wide exact result back to the word width, clamping or wrapping.
// Latency: combinational.
// Backpressure: none.
module fixed_sat #(
    parameter int WORD_LENGTH = 21,
    parameter bit SATURATE    = 1'b1
) (
    input  logic signed [WORD_LENGTH:0]   wide_i,
    output logic signed [WORD_LENGTH-1:0] narrow_o,
    output logic                          ovf_o
);

    localparam logic signed [WORD_LENGTH-1:0] MAX_VAL = {1'b0, {(WORD_LENGTH-1){1'b1}}};
    localparam logic signed [WORD_LENGTH-1:0] MIN_VAL = {1'b1, {(WORD_LENGTH-1){1'b0}}};

    // The extra top bit holds the true sign; if it disagrees with the word's sign bit the
    // value does not fit, and the true sign tells us which rail to clamp to.
    always_comb begin
        ovf_o    = wide_i[WORD_LENGTH] ^ wide_i[WORD_LENGTH-1];
        narrow_o = wide_i[WORD_LENGTH-1:0];
        if (SATURATE && ovf_o) begin
            narrow_o = wide_i[WORD_LENGTH] ? MIN_VAL : MAX_VAL;
        end
    end

endmodule

// File: rtl/fixed_add_sub.sv
// Registered signed fixed-point sum and difference with per-path overflow flags.
// Latency: 1 clock from valid_i to valid_o; one result per cycle.
// Backpressure: none; outputs hold their last result while valid_i is low.
module fixed_add_sub #(
    parameter int WORD_LENGTH = fixed_pkg::WORD_LENGTH,
    parameter int FRAC_BITS   = fixed_pkg::FRAC_BITS,
    parameter bit SATURATE    = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_i,
    input  logic signed [WORD_LENGTH-1:0] a_i,
    input  logic signed [WORD_LENGTH-1:0] b_i,
    output logic                          valid_o,
    output logic signed [WORD_LENGTH-1:0] sum_o,
    output logic signed [WORD_LENGTH-1:0] difference_o,
    output logic                          sum_ovf_o,
    output logic                          diff_ovf_o
);

    // A binary point outside the magnitude bits is a configuration mistake.
    if (FRAC_BITS < 0 || FRAC_BITS > WORD_LENGTH - 1) begin : g_bad_frac
        $error("fixed_add_sub: FRAC_BITS out of range for WORD_LENGTH");
    end

    logic signed [WORD_LENGTH:0]   a_ext;
    logic signed [WORD_LENGTH:0]   b_ext;
    logic signed [WORD_LENGTH:0]   sum_wide;
    logic signed [WORD_LENGTH:0]   diff_wide;
    logic signed [WORD_LENGTH-1:0] sum_nxt;
    logic signed [WORD_LENGTH-1:0] diff_nxt;
    logic                          sum_ovf_nxt;
    logic                          diff_ovf_nxt;

    // One guard bit makes both results exact; subtracting directly (rather than adding
    // a negated b) keeps b = MIN exact as well.
    always_comb begin
        a_ext     = {a_i[WORD_LENGTH-1], a_i};
        b_ext     = {b_i[WORD_LENGTH-1], b_i};
        sum_wide  = a_ext + b_ext;
        diff_wide = a_ext - b_ext;
    end

    fixed_sat #(
        .WORD_LENGTH (WORD_LENGTH),
        .SATURATE    (SATURATE)
    ) u_sat_sum (
        .wide_i   (sum_wide),
        .narrow_o (sum_nxt),
        .ovf_o    (sum_ovf_nxt)
    );

    fixed_sat #(
        .WORD_LENGTH (WORD_LENGTH),
        .SATURATE    (SATURATE)
    ) u_sat_diff (
        .wide_i   (diff_wide),
        .narrow_o (diff_nxt),
        .ovf_o    (diff_ovf_nxt)
    );

    // Output registers: capture on valid_i, otherwise hold the result and drop valid_o.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o      <= 1'b0;
            sum_o        <= '0;
            difference_o <= '0;
            sum_ovf_o    <= 1'b0;
            diff_ovf_o   <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                sum_o        <= sum_nxt;
                difference_o <= diff_nxt;
                sum_ovf_o    <= sum_ovf_nxt;
                diff_ovf_o   <= diff_ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fixed_add_sub.sv
// Scoreboard bench for fixed_add_sub: saturating and wrapping instances side by side.
// Latency: expects each result one clock after its operands.
// Backpressure: none; results are checked as they appear.
module tb_fixed_add_sub;

    localparam int W = 21;

    typedef struct packed {
        logic signed [W-1:0] sum;
        logic signed [W-1:0] diff;
        logic                sovf;
        logic                dovf;
    } res_t;

    logic                clk;
    logic                rst;
    logic                valid_i;
    logic signed [W-1:0] a_i;
    logic signed [W-1:0] b_i;

    logic                valid_o_s, sum_ovf_s, diff_ovf_s;
    logic signed [W-1:0] sum_s, diff_s;
    logic                valid_o_w, sum_ovf_w, diff_ovf_w;
    logic signed [W-1:0] sum_w, diff_w;

    res_t q_sat[$];
    res_t q_wrap[$];
    res_t last_sat;
    res_t last_wrap;
    int   errors = 0;
    int   checks = 0;

    fixed_add_sub #(.WORD_LENGTH(W), .FRAC_BITS(16), .SATURATE(1'b1)) u_dut_sat (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .valid_o      (valid_o_s),
        .sum_o        (sum_s),
        .difference_o (diff_s),
        .sum_ovf_o    (sum_ovf_s),
        .diff_ovf_o   (diff_ovf_s)
    );

    fixed_add_sub #(.WORD_LENGTH(W), .FRAC_BITS(16), .SATURATE(1'b0)) u_dut_wrap (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .valid_o      (valid_o_w),
        .sum_o        (sum_w),
        .difference_o (diff_w),
        .sum_ovf_o    (sum_ovf_w),
        .diff_ovf_o   (diff_ovf_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic res_t mk(input int s, input int d, input bit so, input bit dv);
        res_t r;
        r.sum  = s[W-1:0];
        r.diff = d[W-1:0];
        r.sovf = so;
        r.dovf = dv;
        return r;
    endfunction

    function automatic res_t got_sat();
        return {sum_s, diff_s, sum_ovf_s, diff_ovf_s};
    endfunction

    function automatic res_t got_wrap();
        return {sum_w, diff_w, sum_ovf_w, diff_ovf_w};
    endfunction

    task automatic cmp(input string name, input res_t got, input res_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got sum=%0d diff=%0d sovf=%0b dovf=%0b, want sum=%0d diff=%0d sovf=%0b dovf=%0b",
                     name, got.sum, got.diff, got.sovf, got.dovf, exp.sum, exp.diff, exp.sovf, exp.dovf);
        end
    endtask

    task automatic cmp_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, want %0b", name, got, exp);
        end
    endtask

    // Apply operands now (no clock wait) and record what both flavours must return.
    task automatic put(input int a, input int b, input res_t es, input res_t ew);
        a_i       = a[W-1:0];
        b_i       = b[W-1:0];
        valid_i   = 1'b1;
        q_sat.push_back(es);
        q_wrap.push_back(ew);
        last_sat  = es;
        last_wrap = ew;
    endtask

    task automatic drive(input int a, input int b, input res_t es, input res_t ew);
        @(negedge clk);
        put(a, b, es, ew);
    endtask

    task automatic check_zero(input string name);
        cmp({name, "_sat"},  got_sat(),  mk(0, 0, 1'b0, 1'b0));
        cmp({name, "_wrap"}, got_wrap(), mk(0, 0, 1'b0, 1'b0));
        cmp_bit({name, "_vld_sat"},  valid_o_s, 1'b0);
        cmp_bit({name, "_vld_wrap"}, valid_o_w, 1'b0);
    endtask

    // Monitor: every valid output is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_o_s) begin
                if (q_sat.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sat_unexpected: got valid_o=1, want no output");
                end else begin
                    cmp("sat_result", got_sat(), q_sat.pop_front());
                end
            end
            if (valid_o_w) begin
                if (q_wrap.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wrap_unexpected: got valid_o=1, want no output");
                end else begin
                    cmp("wrap_result", got_wrap(), q_wrap.pop_front());
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        #1;
        check_zero("reset_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset_clocked");
        rst = 1'b0;

        // Directed vectors: a, b, saturating expectation, wrapping expectation.
        drive(65536, 32768,       mk(98304, 32768, 0, 0),       mk(98304, 32768, 0, 0));
        drive(-3, 5,              mk(2, -8, 0, 0),              mk(2, -8, 0, 0));
        drive(1048575, 1,         mk(1048575, 1048574, 1, 0),   mk(-1048576, 1048574, 1, 0));
        drive(-1048576, 1,        mk(-1048575, -1048576, 0, 1), mk(-1048575, 1048575, 0, 1));
        drive(0, -1048576,        mk(-1048576, 1048575, 0, 1),  mk(-1048576, -1048576, 0, 1));
        drive(-1048576, -1048576, mk(-1048576, 0, 1, 0),        mk(0, 0, 1, 0));
        drive(43981, -1,          mk(43980, 43982, 0, 0),       mk(43980, 43982, 0, 0));
        drive(1048575, -1048576,  mk(-1, 1048575, 0, 1),        mk(-1, -1, 0, 1));

        // Idle: valid_o drops and the last result stays on the outputs.
        @(negedge clk);
        valid_i = 1'b0;
        a_i     = 21'sd12345;
        b_i     = 21'sd777;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp_bit("hold_vld_sat",  valid_o_s, 1'b0);
            cmp_bit("hold_vld_wrap", valid_o_w, 1'b0);
            cmp("hold_sat",  got_sat(),  last_sat);
            cmp("hold_wrap", got_wrap(), last_wrap);
        end

        // Reset mid-stream: the operands in flight when reset rises must never emerge.
        drive(74565, 273, mk(74838, 74292, 0, 0), mk(74838, 74292, 0, 0));
        @(negedge clk);
        a_i     = 21'sd1048575;
        b_i     = -21'sd1048576;
        valid_i = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_zero("reset_mid_async");
        @(posedge clk);
        @(negedge clk);
        check_zero("reset_mid_clocked");
        rst = 1'b0;
        put(5, 3, mk(8, 2, 0, 0), mk(8, 2, 0, 0));
        @(negedge clk);
        valid_i = 1'b0;
        repeat (2) @(negedge clk);

        // Every expected result must have been seen.
        checks++;
        if (q_sat.size() != 0 || q_wrap.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d sat and %0d wrap results still pending, want 0",
                     q_sat.size(), q_wrap.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
